// File: rtl/mux4to1_if.sv
// ============================================================================
// Module      : mux4to1_if
// Description : Bundle of the four sources, select/enable and the result
//               outputs that connect a mux4to1 instance to its user.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux4to1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic             chg;

    // The user drives the sources; the mux drives the results.
    modport master (
        output a, b, c, d, s, en,
        input  out, out_q, sel_q, chg
    );

    modport slave (
        input  a, b, c, d, s, en,
        output out, out_q, sel_q, chg
    );
endinterface : mux4to1_if

`default_nettype wire

// File: rtl/mux4to1.sv
// ============================================================================
// Module      : mux4to1
// Description : 4:1 selector with a combinational output, plus a registered
//               copy of the selected value, the select, and a change pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4to1 #(
    parameter int WIDTH = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mux4to1_if.slave  bus
);

    logic [WIDTH-1:0] w_out;
    logic             w_chg_d;
    logic [WIDTH-1:0] r_out_q;
    logic [1:0]       r_sel_q;
    logic             r_chg_q;

    always_comb begin
        w_out = bus.a;
        case (bus.s)
            2'b00:   w_out = bus.a;
            2'b01:   w_out = bus.b;
            2'b10:   w_out = bus.c;
            default: w_out = bus.d;
        endcase
    end

    // A select-only change that captures the same data must not pulse chg.
    assign w_chg_d = (w_out != r_out_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_q <= '0;
            r_sel_q <= 2'b00;
            r_chg_q <= 1'b0;
        end else if (bus.en) begin
            r_out_q <= w_out;
            r_sel_q <= bus.s;
            r_chg_q <= w_chg_d;
        end else begin
            r_chg_q <= 1'b0;
        end
    end

    assign bus.out   = w_out;
    assign bus.out_q = r_out_q;
    assign bus.sel_q = r_sel_q;
    assign bus.chg   = r_chg_q;

endmodule : mux4to1

`default_nettype wire

// File: tb/tb_mux4to1.sv
// ============================================================================
// Module      : tb_mux4to1
// Description : Directed bench for mux4to1 at WIDTH=1 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4to1;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mux4to1_if #(.WIDTH(1)) bus1 ();
    mux4to1_if #(.WIDTH(8)) bus8 ();

    mux4to1 #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mux4to1 #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input logic [1:0] s, input logic a, input logic b,
                        input logic c, input logic d);
        bus1.s = s;
        bus1.a = a;
        bus1.b = b;
        bus1.c = c;
        bus1.d = d;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus1.en = 1'b0;
        set1(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        bus8.en = 1'b0;
        bus8.s  = 2'b00;
        bus8.a  = 8'h11;
        bus8.b  = 8'h22;
        bus8.c  = 8'h33;
        bus8.d  = 8'h44;

        // Combinational sweep, 20 ns per vector
        set1(2'b00, 0, 0, 0, 0); #1; chk("sweep0", bus1.out, 1'b0); #19;
        set1(2'b01, 0, 0, 0, 1); #1; chk("sweep1", bus1.out, 1'b0); #19;
        set1(2'b10, 1, 0, 1, 0); #1; chk("sweep2", bus1.out, 1'b1); #19;
        set1(2'b11, 0, 0, 1, 0); #1; chk("sweep3", bus1.out, 1'b0); #19;
        set1(2'b00, 0, 0, 1, 1); #1; chk("sweep4", bus1.out, 1'b0); #19;
        set1(2'b01, 0, 1, 0, 0); #1; chk("sweep5", bus1.out, 1'b1); #19;
        set1(2'b10, 0, 1, 0, 1); #1; chk("sweep6", bus1.out, 1'b0); #19;
        set1(2'b11, 0, 1, 1, 1); #1; chk("sweep7", bus1.out, 1'b1); #19;

        // Reset beats en; out stays live
        rst_n   = 1'b0;
        bus1.en = 1'b1;
        set1(2'b10, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_q", bus1.out_q, 1'b0);
            chk("rst_sel_q", bus1.sel_q, 2'b00);
            chk("rst_chg",   bus1.chg,   1'b0);
            chk("rst_out",   bus1.out,   1'b1);
        end

        // First load after reset compares against zero
        rst_n = 1'b1;
        set1(2'b01, 0, 1, 0, 0);
        tick();
        chk("load_out_q", bus1.out_q, 1'b1);
        chk("load_sel_q", bus1.sel_q, 2'b01);
        chk("load_chg",   bus1.chg,   1'b1);
        tick();
        chk("reload_out_q", bus1.out_q, 1'b1);
        chk("reload_chg",   bus1.chg,   1'b0);

        // Enable low: registers hold while out tracks inputs
        bus1.en = 1'b0;
        set1(2'b11, 0, 1, 0, 0);
        #1;
        chk("hold_out", bus1.out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_out_q", bus1.out_q, 1'b1);
            chk("hold_sel_q", bus1.sel_q, 2'b01);
            chk("hold_chg",   bus1.chg,   1'b0);
        end

        // Select-only change leaves chg low
        bus1.en = 1'b1;
        set1(2'b00, 1, 1, 0, 0);
        tick();
        chk("sel00_sel_q", bus1.sel_q, 2'b00);
        chk("sel00_out_q", bus1.out_q, 1'b1);
        chk("sel00_chg",   bus1.chg,   1'b0);
        bus1.s = 2'b01;
        tick();
        chk("sel01_sel_q", bus1.sel_q, 2'b01);
        chk("sel01_out_q", bus1.out_q, 1'b1);
        chk("sel01_chg",   bus1.chg,   1'b0);

        // Load of a new value pulses chg for exactly one cycle
        bus1.s = 2'b10;
        tick();
        chk("fall_out_q", bus1.out_q, 1'b0);
        chk("fall_chg",   bus1.chg,   1'b1);
        bus1.en = 1'b0;
        tick();
        chk("pulse_end_chg", bus1.chg,   1'b0);
        chk("pulse_end_q",   bus1.out_q, 1'b0);

        // WIDTH=8 sweep with reset in the middle
        bus8.en = 1'b1;
        bus8.s  = 2'b00; #1;
        chk("w8_out0", bus8.out, 8'h11);
        tick();
        chk("w8_q0",   bus8.out_q, 8'h11);
        chk("w8_sel0", bus8.sel_q, 2'b00);
        chk("w8_chg0", bus8.chg,   1'b1);
        bus8.s = 2'b01; #1;
        chk("w8_out1", bus8.out, 8'h22);
        tick();
        chk("w8_q1",   bus8.out_q, 8'h22);
        chk("w8_chg1", bus8.chg,   1'b1);
        bus8.s = 2'b10; #1;
        chk("w8_out2", bus8.out, 8'h33);
        tick();
        chk("w8_q2",   bus8.out_q, 8'h33);
        chk("w8_sel2", bus8.sel_q, 2'b10);
        chk("w8_chg2", bus8.chg,   1'b1);
        bus8.s = 2'b11;
        rst_n  = 1'b0;
        tick();
        chk("w8_rst_q",   bus8.out_q, 8'h00);
        chk("w8_rst_sel", bus8.sel_q, 2'b00);
        chk("w8_rst_chg", bus8.chg,   1'b0);
        chk("w8_rst_out", bus8.out,   8'h44);
        rst_n = 1'b1;
        tick();
        chk("w8_q3",   bus8.out_q, 8'h44);
        chk("w8_sel3", bus8.sel_q, 2'b11);
        chk("w8_chg3", bus8.chg,   1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule : tb_mux4to1

`default_nettype wire
